// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone initiator.
// State encoding, user BRAM window base and ack-timer width.
package wb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] USER_BRAM_BASE = 32'h3800_0000;
    localparam int unsigned TIMER_W        = 8;

    // Counter value seen on the last permitted bus cycle (cycle 1 reads 0).
    function automatic logic [TIMER_W-1:0] timer_limit(input int unsigned timeout);
        return TIMER_W'(timeout - 1);
    endfunction

endpackage

// File: rtl/wb_initiator_if.sv
// Command, response and Wishbone bus signals of wb_initiator.
// master: the initiator side; slave: the command source / responder side.
interface wb_initiator_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_adr;
    logic [SEL_W-1:0]  cmd_sel;
    logic [DATA_W-1:0] cmd_dat;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_dat;
    logic              rsp_err;

    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [SEL_W-1:0]  wbm_sel_o;
    logic [ADDR_W-1:0] wbm_adr_o;
    logic [DATA_W-1:0] wbm_dat_o;
    logic [DATA_W-1:0] wbm_dat_i;
    logic              wbm_ack_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat,
        input  rsp_ready, wbm_dat_i, wbm_ack_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat,
        output rsp_ready, wbm_dat_i, wbm_ack_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

endinterface

// File: rtl/wb_ack_timer.sv
// Bus-cycle counter for the ack timeout: cleared on command accept, counts while in BUS.
// o_expire marks bus cycle number TIMEOUT.
module wb_ack_timer
    import wb_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    logic [TIMER_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_cnt == timer_limit(TIMEOUT));

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: one bus cycle per accepted command.
// Define WB_INIT_TIMEOUT_EN to abort cycles not acked within TIMEOUT bus cycles.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input logic            wb_clk_i,
    input logic            wb_rst_i,
    wb_initiator_if.master bus
);
    localparam int unsigned SEL_W = DATA_W / 8;

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_adr;
    logic [SEL_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_dat;
    logic [DATA_W-1:0] r_rsp_dat;
    logic              w_rsp_err;
    logic              w_accept;
    logic              w_ack;
    logic              w_expire;

    assign w_accept = (r_state == IDLE) && bus.cmd_valid;
    assign w_ack    = (r_state == BUS)  && bus.wbm_ack_i;

`ifdef WB_INIT_TIMEOUT_EN
    logic r_rsp_err;

    wb_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .i_clk    (wb_clk_i),
        .i_rst_n  (wb_rst_i),
        .i_clear  (w_accept),
        .i_enable (r_state == BUS),
        .o_expire (w_expire)
    );

    // An ack on the expiring cycle wins over the abort.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_rsp_err <= 1'b0;
        end else if (w_ack) begin
            r_rsp_err <= 1'b0;
        end else if (w_expire) begin
            r_rsp_err <= 1'b1;
        end
    end

    assign w_rsp_err = r_rsp_err;
`else
    assign w_expire  = 1'b0;
    assign w_rsp_err = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.cmd_valid)           w_next = BUS;
            BUS:     if (w_ack || w_expire)       w_next = RESP;
            RESP:    if (bus.rsp_ready)           w_next = IDLE;
            default:                              w_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_sel     <= '0;
            r_dat     <= '0;
            r_rsp_dat <= '0;
        end else begin
            if (w_accept) begin
                r_we  <= bus.cmd_we;
                r_adr <= bus.cmd_adr;
                r_sel <= bus.cmd_sel;
                r_dat <= bus.cmd_dat;
            end
            if (w_ack) begin
                r_rsp_dat <= r_we ? '0 : bus.wbm_dat_i;
            end else if (w_expire) begin
                r_rsp_dat <= '0;
            end
        end
    end

    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_dat   = '0;
        bus.rsp_err   = 1'b0;
        bus.wbm_cyc_o = 1'b0;
        bus.wbm_stb_o = 1'b0;
        bus.wbm_we_o  = 1'b0;
        bus.wbm_sel_o = '0;
        bus.wbm_adr_o = '0;
        bus.wbm_dat_o = '0;
        case (r_state)
            IDLE: bus.cmd_ready = 1'b1;
            BUS: begin
                bus.wbm_cyc_o = 1'b1;
                bus.wbm_stb_o = 1'b1;
                bus.wbm_we_o  = r_we;
                bus.wbm_sel_o = r_sel;
                bus.wbm_adr_o = r_adr;
                bus.wbm_dat_o = r_dat;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_dat   = r_rsp_dat;
                bus.rsp_err   = w_rsp_err;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator with a programmable-latency BRAM responder.
// Timeout sequence runs only when WB_INIT_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_wb_initiator;
    import wb_initiator_pkg::*;

    localparam int unsigned TO = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_initiator_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    wb_initiator #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (bus)
    );

    // Responder: acks on bus cycle ack_n (0 = never); stray forces an ack pulse.
    int          ack_n   = 0;
    int          bus_cnt = 0;
    logic        stray   = 1'b0;
    logic [31:0] mem [16] = '{default: 32'h0};

    assign bus.wbm_ack_i = stray || (bus.wbm_stb_o && ack_n != 0 && bus_cnt + 1 == ack_n);
    assign bus.wbm_dat_i = mem[bus.wbm_adr_o[5:2]];

    always @(posedge clk) begin
        if (bus.wbm_stb_o && !bus.wbm_ack_i) bus_cnt <= bus_cnt + 1;
        else                                 bus_cnt <= 0;
        if (bus.wbm_stb_o && bus.wbm_ack_i && bus.wbm_we_o)
            for (int b = 0; b < 4; b++)
                if (bus.wbm_sel_o[b])
                    mem[bus.wbm_adr_o[5:2]][b*8 +: 8] <= bus.wbm_dat_o[b*8 +: 8];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input string tag, input logic we, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat, input int ack,
                           input int hold, input logic [31:0] exp_dat, input logic exp_err,
                           input int exp_lat, input int exp_stb);
        int          n;
        int          lat;
        int          stb_n;
        logic        bus_ok;
        logic        idle_ok;
        logic        hold_ok;
        logic [31:0] rdat;
        logic        err;
        ack_n = ack;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_sel   = sel;
        bus.cmd_dat   = dat;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = ~we;
        bus.cmd_adr   = ~adr;
        bus.cmd_sel   = ~sel;
        bus.cmd_dat   = ~dat;
        lat    = 1;
        stb_n  = 0;
        bus_ok = 1'b1;
        while (!bus.rsp_valid && lat < 300) begin
            if (bus.wbm_stb_o) begin
                stb_n++;
                if (!bus.wbm_cyc_o || bus.wbm_we_o !== we || bus.wbm_adr_o !== adr ||
                    bus.wbm_sel_o !== sel || bus.wbm_dat_o !== dat)
                    bus_ok = 1'b0;
            end
            if (bus.cmd_ready) bus_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        rdat    = bus.rsp_dat;
        err     = bus.rsp_err;
        idle_ok = !bus.wbm_cyc_o && !bus.wbm_stb_o && !bus.wbm_we_o && bus.wbm_adr_o == 32'h0 &&
                  bus.wbm_sel_o == 4'h0 && bus.wbm_dat_o == 32'h0 && !bus.cmd_ready;
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (i == 1) stray = 1'b1;
            @(negedge clk);
            stray = 1'b0;
            if (!bus.rsp_valid || bus.rsp_dat !== rdat || bus.rsp_err !== err ||
                bus.cmd_ready || bus.wbm_cyc_o)
                hold_ok = 1'b0;
        end
        check({tag, "_lat"},    32'(lat),     32'(exp_lat));
        check({tag, "_stb"},    32'(stb_n),   32'(exp_stb));
        check({tag, "_dat"},    rdat,         exp_dat);
        check({tag, "_err"},    32'(err),     32'(exp_err));
        check({tag, "_busdrv"}, 32'(bus_ok),  32'd1);
        check({tag, "_resp"},   32'(idle_ok), 32'd1);
        if (hold > 0) check({tag, "_hold"}, 32'(hold_ok), 32'd1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_post"}, 32'({bus.cmd_ready, bus.rsp_valid}), 32'b10);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          ack;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_lat;
        int          exp_stb;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        vecs[0] = '{1'b1, USER_BRAM_BASE + 32'h4, 4'hF,    32'hDEAD_BEEF, 11, 32'h0,         1'b0, 12, 11};
        vecs[1] = '{1'b0, USER_BRAM_BASE + 32'h4, 4'hF,    32'h0,          1, 32'hDEAD_BEEF, 1'b0,  2,  1};
        vecs[2] = '{1'b1, USER_BRAM_BASE + 32'h8, 4'b0101, 32'h1122_3344,  2, 32'h0,         1'b0,  3,  2};
        vecs[3] = '{1'b0, USER_BRAM_BASE + 32'h8, 4'hF,    32'h5A5A_0F0F,  3, 32'h0022_0044, 1'b0,  4,  3};
        vecs[4] = '{1'b0, USER_BRAM_BASE + 32'h4, 4'hF,    32'h0,         TO, 32'hDEAD_BEEF, 1'b0, TO + 1, TO};

        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = '0;
        bus.cmd_sel   = '0;
        bus.cmd_dat   = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_cyc_stb",   32'({bus.wbm_cyc_o, bus.wbm_stb_o}), 32'd0);
        check("rst_adr",       bus.wbm_adr_o, 32'h0);
        check("rst_rsp_dat",   bus.rsp_dat, 32'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++)
            run_cmd($sformatf("vec%0d", v), vecs[v].we, vecs[v].adr, vecs[v].sel, vecs[v].dat,
                    vecs[v].ack, 0, vecs[v].exp_dat, vecs[v].exp_err, vecs[v].exp_lat, vecs[v].exp_stb);

        // Response stalled for 5 cycles with a stray ack pulse inside the stall.
        run_cmd("stall", 1'b0, USER_BRAM_BASE + 32'h8, 4'hF, 32'h0, 2, 5,
                32'h0022_0044, 1'b0, 3, 2);

        // Stray ack while idle must not start or complete anything.
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        check("stray_idle", 32'({bus.cmd_ready, bus.rsp_valid, bus.wbm_cyc_o}), 32'b100);
        run_cmd("after_stray", 1'b0, USER_BRAM_BASE + 32'h4, 4'hF, 32'h0, 4, 0,
                32'hDEAD_BEEF, 1'b0, 5, 4);

`ifdef WB_INIT_TIMEOUT_EN
        run_cmd("timeout", 1'b1, USER_BRAM_BASE + 32'hC, 4'hF, 32'hCAFE_F00D, 0, 0,
                32'h0, 1'b1, TO + 1, TO);
        run_cmd("after_to", 1'b0, USER_BRAM_BASE + 32'hC, 4'hF, 32'h0, 1, 0,
                32'h0, 1'b0, 2, 1);
`endif

        // Reset asserted during bus cycle 4 of a never-acked read.
        ack_n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = USER_BRAM_BASE + 32'h4;
        bus.cmd_sel   = 4'hF;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid_pre_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_drop", 32'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid}), 32'd0);
        check("rstmid_ready", 32'(bus.cmd_ready), 32'd1);
        rst_n = 1'b1;
        ack_n = 3;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.wbm_cyc_o || !bus.cmd_ready) n++;
        end
        check("rstmid_quiet", 32'(n), 32'd0);
        run_cmd("after_rst", 1'b0, USER_BRAM_BASE + 32'h4, 4'hF, 32'h0, 2, 0,
                32'hDEAD_BEEF, 1'b0, 3, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
